// File: rtl/dcp_dispatch.sv
// rtl/dcp_dispatch.sv - command dispatcher: fetch a code, route SCAN/PRINT/address to the matching child
module dcp_dispatch #(
    parameter int               NCH       = 8,
    parameter int               DW        = 32,
    parameter int               AW        = 32,
    parameter logic [NCH*8-1:0] CMD_CODES = {"L", "G", "B", "T", "P", "I", "D", "R"},
    parameter int               TIMEOUT   = 1048576,
    parameter logic [7:0]       ERR_CHAR  = 8'h3F
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              req_rx,
    output logic              type_rx,
    input  logic              ack_rx,
    input  logic              flag_rx,
    input  logic [DW-1:0]     din_rx,
    output logic              req_tx,
    output logic              type_tx,
    output logic [DW-1:0]     dout_tx,
    input  logic              ack_tx,
    output logic [NCH-1:0]    ch_sel,
    input  logic [NCH-1:0]    ch_req_rx,
    input  logic [NCH-1:0]    ch_type_rx,
    input  logic [NCH-1:0]    ch_req_tx,
    input  logic [NCH-1:0]    ch_type_tx,
    input  logic [NCH-1:0]    ch_finish,
    input  logic [NCH*DW-1:0] ch_dout,
    input  logic [NCH*AW-1:0] ch_addr,
    output logic [AW-1:0]     addr,
    output logic              busy,
    output logic [7:0]        last_cmd,
    output logic [7:0]        err_cnt
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WD_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_RUN,
        S_ERR,
        S_ABORT
    } state_t;

    state_t        state, state_d;
    logic [7:0]    code_q;
    logic [IW-1:0] idx_q;
    logic [WW-1:0] wd_cnt;
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic          wd_expire;
    logic [7:0]    err_inc;

    // Descending scan so the lowest matching slot is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (CMD_CODES[8*k +: 8] == code_q) begin
                hit     = 1'b1;
                hit_idx = IW'(k);
            end
        end
    end

    // RUN lasts exactly TIMEOUT cycles: the count starts at 0 on entry.
    assign wd_expire = (TIMEOUT > 0) && (wd_cnt == WD_LAST);
    assign err_inc   = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_d = state;
        req_rx  = 1'b0;
        type_rx = 1'b0;
        req_tx  = 1'b0;
        type_tx = 1'b0;
        dout_tx = '0;
        addr    = '0;
        case (state)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                req_rx = 1'b1;
                if (ack_rx) state_d = flag_rx ? S_IDLE : S_DECODE;
            end
            S_DECODE: state_d = hit ? S_RUN : S_ERR;
            S_RUN: begin
                req_rx  = ch_req_rx[idx_q];
                type_rx = ch_type_rx[idx_q];
                req_tx  = ch_req_tx[idx_q];
                type_tx = ch_type_tx[idx_q];
                dout_tx = ch_dout[idx_q*DW +: DW];
                addr    = ch_addr[idx_q*AW +: AW];
                if (ch_finish[idx_q]) state_d = S_IDLE;
                else if (wd_expire)   state_d = S_ABORT;
            end
            S_ERR, S_ABORT: begin
                req_tx  = 1'b1;
                dout_tx = DW'(ERR_CHAR);
                if (ack_tx) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            code_q   <= '0;
            idx_q    <= '0;
            wd_cnt   <= '0;
            ch_sel   <= '0;
            last_cmd <= '0;
            err_cnt  <= '0;
        end else begin
            state <= state_d;
            if (state == S_FETCH && ack_rx && !flag_rx) code_q <= din_rx[7:0];
            if (state == S_DECODE) begin
                wd_cnt <= '0;
                if (hit) begin
                    idx_q    <= hit_idx;
                    last_cmd <= code_q;
                    ch_sel   <= NCH'(1) << hit_idx;
                end else begin
                    err_cnt <= err_inc;
                end
            end
            if (state == S_RUN) begin
                if (TIMEOUT > 0)         wd_cnt  <= wd_cnt + WW'(1);
                if (state_d != S_RUN)    ch_sel  <= '0;
                if (state_d == S_ABORT)  err_cnt <= err_inc;
            end
        end
    end

endmodule

// File: tb/tb_dcp_dispatch.sv
// tb/tb_dcp_dispatch.sv - directed-vector bench for dcp_dispatch
module tb_dcp_dispatch;

    localparam int NCH = 8;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam logic [63:0] CODES = {"L", "G", "P", "T", "X", "P", "D", "R"};

    logic              clk = 1'b0;
    logic              rstn;
    logic              req_rx, type_rx, ack_rx, flag_rx;
    logic [DW-1:0]     din_rx;
    logic              req_tx, type_tx, ack_tx;
    logic [DW-1:0]     dout_tx;
    logic [NCH-1:0]    ch_sel;
    logic [NCH-1:0]    ch_req_rx, ch_type_rx, ch_req_tx, ch_type_tx, ch_finish;
    logic [NCH*DW-1:0] ch_dout;
    logic [NCH*AW-1:0] ch_addr;
    logic [AW-1:0]     addr;
    logic              busy;
    logic [7:0]        last_cmd, err_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    dcp_dispatch #(
        .NCH(NCH), .DW(DW), .AW(AW), .CMD_CODES(CODES), .TIMEOUT(16), .ERR_CHAR(8'h3F)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_rx(req_rx), .type_rx(type_rx), .ack_rx(ack_rx), .flag_rx(flag_rx), .din_rx(din_rx),
        .req_tx(req_tx), .type_tx(type_tx), .dout_tx(dout_tx), .ack_tx(ack_tx),
        .ch_sel(ch_sel), .ch_req_rx(ch_req_rx), .ch_type_rx(ch_type_rx),
        .ch_req_tx(ch_req_tx), .ch_type_tx(ch_type_tx), .ch_finish(ch_finish),
        .ch_dout(ch_dout), .ch_addr(ch_addr), .addr(addr),
        .busy(busy), .last_cmd(last_cmd), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_children();
        ch_req_rx = '0; ch_type_rx = '0; ch_req_tx = '0; ch_type_tx = '0; ch_finish = '0;
        ch_dout = '0; ch_addr = '0;
    endtask

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (req_rx === 1'b1 && type_rx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Presents a character on SCAN for exactly one sampling edge.
    task automatic send_char(input logic [7:0] c, input logic flag);
        din_rx = {24'h0, c}; flag_rx = flag; ack_rx = 1'b1;
        step();
        ack_rx = 1'b0; flag_rx = 1'b0; din_rx = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; ack_rx = 0; flag_rx = 0; din_rx = '0; ack_tx = 0;
        clear_children();
        #3;
        tests_run++;
        if ({req_rx, type_rx, req_tx, type_tx, busy} !== 5'b0 || dout_tx !== '0 || addr !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: req_rx=%b req_tx=%b busy=%b dout_tx=%h addr=%h, want all 0",
                     req_rx, req_tx, busy, dout_tx, addr);
        end
        tests_run++;
        if (ch_sel !== 8'h00 || err_cnt !== 8'h00 || last_cmd !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_regs: ch_sel=%h err_cnt=%h last_cmd=%h, want 00/00/00", ch_sel, err_cnt, last_cmd);
        end
        #9 rstn = 1'b1;
        step();
        tests_run++;
        if (req_rx !== 1'b1 || type_rx !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_first_fetch: req_rx=%b type_rx=%b busy=%b, want 1/0/1", req_rx, type_rx, busy);
        end
    endtask

    task automatic test_known_cmd();
        bit ok;
        wait_fetch(ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL known_wait_fetch: req_rx=%b, want 1", req_rx); end
        ch_dout[1*DW +: DW] = 32'h1234_5678; ch_addr[1*AW +: AW] = 32'hA000_0001;
        ch_req_tx[1] = 1'b1; ch_type_tx[1] = 1'b1;
        ch_dout[0 +: DW] = 32'hDEAD_BEEF; ch_req_tx[0] = 1'b1; ch_req_rx[0] = 1'b1;
        send_char(8'h44, 1'b0);
        tests_run++;
        if (ch_sel !== 8'h00 || req_tx !== 1'b0 || addr !== '0) begin
            tests_failed++;
            $display("FAIL known_decode: ch_sel=%h req_tx=%b addr=%h, want 00/0/0", ch_sel, req_tx, addr);
        end
        step();
        tests_run++;
        if (ch_sel !== 8'b0000_0010 || last_cmd !== 8'h44) begin
            tests_failed++;
            $display("FAIL known_sel: ch_sel=%b last_cmd=%h, want 00000010/44", ch_sel, last_cmd);
        end
        tests_run++;
        if (req_tx !== 1'b1 || type_tx !== 1'b1 || dout_tx !== 32'h1234_5678 || addr !== 32'hA000_0001 || req_rx !== 1'b0) begin
            tests_failed++;
            $display("FAIL known_route: req_tx=%b type_tx=%b dout_tx=%h addr=%h req_rx=%b, want 1/1/12345678/a0000001/0",
                     req_tx, type_tx, dout_tx, addr, req_rx);
        end
        ch_finish[1] = 1'b1;
        step();
        ch_finish[1] = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || ch_sel !== 8'h00 || req_tx !== 1'b0 || addr !== '0) begin
            tests_failed++;
            $display("FAIL known_finish: busy=%b ch_sel=%h req_tx=%b addr=%h, want 0/00/0/0", busy, ch_sel, req_tx, addr);
        end
        step();
        tests_run++;
        if (req_rx !== 1'b1 || err_cnt !== 8'h00 || last_cmd !== 8'h44) begin
            tests_failed++;
            $display("FAIL known_refetch: req_rx=%b err_cnt=%h last_cmd=%h, want 1/00/44", req_rx, err_cnt, last_cmd);
        end
        clear_children();
    endtask

    task automatic test_unknown_cmd();
        send_char(8'h5A, 1'b0);
        step();
        tests_run++;
        if (req_tx !== 1'b1 || type_tx !== 1'b0 || dout_tx !== 32'h0000_003F || err_cnt !== 8'h01 || ch_sel !== 8'h00) begin
            tests_failed++;
            $display("FAIL unknown_err: req_tx=%b type_tx=%b dout_tx=%h err_cnt=%h ch_sel=%h, want 1/0/0000003f/01/00",
                     req_tx, type_tx, dout_tx, err_cnt, ch_sel);
        end
        step();
        tests_run++;
        if (req_tx !== 1'b1 || dout_tx !== 32'h0000_003F) begin
            tests_failed++;
            $display("FAIL unknown_hold: req_tx=%b dout_tx=%h, want 1/0000003f", req_tx, dout_tx);
        end
        ack_tx = 1'b1;
        step();
        ack_tx = 1'b0;
        tests_run++;
        if (req_tx !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL unknown_drop: req_tx=%b busy=%b, want 0/0", req_tx, busy);
        end
        step();
        tests_run++;
        if (req_rx !== 1'b1 || err_cnt !== 8'h01) begin
            tests_failed++;
            $display("FAIL unknown_refetch: req_rx=%b err_cnt=%h, want 1/01", req_rx, err_cnt);
        end
    endtask

    task automatic test_empty_line();
        send_char(8'h00, 1'b1);
        tests_run++;
        if (req_rx !== 1'b0 || req_tx !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_idle: req_rx=%b req_tx=%b busy=%b, want 0/0/0", req_rx, req_tx, busy);
        end
        step();
        tests_run++;
        if (req_rx !== 1'b1 || req_tx !== 1'b0 || err_cnt !== 8'h01) begin
            tests_failed++;
            $display("FAIL empty_refetch: req_rx=%b req_tx=%b err_cnt=%h, want 1/0/01", req_rx, req_tx, err_cnt);
        end
    endtask

    task automatic test_timeout();
        bit held = 1'b1;
        ch_req_rx[6] = 1'b1;
        send_char(8'h47, 1'b0);
        step();
        tests_run++;
        if (ch_sel !== 8'b0100_0000 || req_rx !== 1'b1 || last_cmd !== 8'h47) begin
            tests_failed++;
            $display("FAIL timeout_sel: ch_sel=%b req_rx=%b last_cmd=%h, want 01000000/1/47", ch_sel, req_rx, last_cmd);
        end
        for (int i = 2; i <= 16; i++) begin
            step();
            if (ch_sel !== 8'b0100_0000) held = 1'b0;
        end
        tests_run++;
        if (held !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_early: ch_sel=%b, want held 01000000 for 16 RUN cycles", ch_sel);
        end
        step();
        tests_run++;
        if (ch_sel !== 8'h00 || req_tx !== 1'b1 || dout_tx !== 32'h0000_003F || err_cnt !== 8'h02 || req_rx !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_abort: ch_sel=%h req_tx=%b dout_tx=%h err_cnt=%h req_rx=%b, want 00/1/0000003f/02/0",
                     ch_sel, req_tx, dout_tx, err_cnt, req_rx);
        end
        ack_tx = 1'b1;
        step();
        ack_tx = 1'b0;
        step();
        tests_run++;
        if (req_rx !== 1'b1 || req_tx !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_refetch: req_rx=%b req_tx=%b, want 1/0", req_rx, req_tx);
        end
        clear_children();
    endtask

    task automatic test_finish_vs_timeout();
        send_char(8'h47, 1'b0);
        step();
        for (int i = 2; i <= 16; i++) step();
        ch_finish[6] = 1'b1;
        step();
        ch_finish[6] = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || req_tx !== 1'b0 || err_cnt !== 8'h02 || ch_sel !== 8'h00) begin
            tests_failed++;
            $display("FAIL finish_wins: busy=%b req_tx=%b err_cnt=%h ch_sel=%h, want 0/0/02/00", busy, req_tx, err_cnt, ch_sel);
        end
        step();
    endtask

    task automatic test_duplicate_code();
        send_char(8'h50, 1'b0);
        step();
        tests_run++;
        if (ch_sel !== 8'b0000_0100) begin
            tests_failed++;
            $display("FAIL dup_sel: ch_sel=%b, want 00000100", ch_sel);
        end
        ch_finish[5] = 1'b1;
        step();
        ch_finish[5] = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || ch_sel !== 8'b0000_0100) begin
            tests_failed++;
            $display("FAIL dup_foreign_finish: busy=%b ch_sel=%b, want 1/00000100", busy, ch_sel);
        end
        ch_finish[2] = 1'b1;
        step();
        ch_finish[2] = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || ch_sel !== 8'h00 || last_cmd !== 8'h50) begin
            tests_failed++;
            $display("FAIL dup_finish: busy=%b ch_sel=%h last_cmd=%h, want 0/00/50", busy, ch_sel, last_cmd);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        ch_req_tx[7] = 1'b1; ch_dout[7*DW +: DW] = 32'hCAFE_0007; ch_addr[7*AW +: AW] = 32'h0000_7000;
        send_char(8'h4C, 1'b0);
        step();
        tests_run++;
        if (req_tx !== 1'b1 || dout_tx !== 32'hCAFE_0007 || ch_sel !== 8'h80) begin
            tests_failed++;
            $display("FAIL rstrun_pre: req_tx=%b dout_tx=%h ch_sel=%h, want 1/cafe0007/80", req_tx, dout_tx, ch_sel);
        end
        #2 rstn = 1'b0;
        #1;
        tests_run++;
        if (req_tx !== 1'b0 || dout_tx !== '0 || addr !== '0 || ch_sel !== 8'h00 || busy !== 1'b0 ||
            err_cnt !== 8'h00 || last_cmd !== 8'h00) begin
            tests_failed++;
            $display("FAIL rstrun_async: req_tx=%b dout_tx=%h addr=%h ch_sel=%h busy=%b err_cnt=%h last_cmd=%h, want all 0",
                     req_tx, dout_tx, addr, ch_sel, busy, err_cnt, last_cmd);
        end
        #2 rstn = 1'b1;
        step();
        tests_run++;
        if (req_rx !== 1'b1 || req_tx !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstrun_resume: req_rx=%b req_tx=%b, want 1/0", req_rx, req_tx);
        end
        clear_children();
    endtask

    task automatic test_err_saturation();
        bit ok;
        bit all_fetch = 1'b1;
        for (int n = 0; n < 260; n++) begin
            wait_fetch(ok);
            if (!ok) all_fetch = 1'b0;
            send_char(8'h5A, 1'b0);
            step();
            ack_tx = 1'b1;
            step();
            ack_tx = 1'b0;
        end
        tests_run++;
        if (all_fetch !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_loop: a FETCH did not appear within 8 cycles, req_rx=%b", req_rx);
        end
        tests_run++;
        if (err_cnt !== 8'hFF) begin
            tests_failed++;
            $display("FAIL sat_err_cnt: err_cnt=%h, want ff", err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_known_cmd();
        test_unknown_cmd();
        test_empty_line();
        test_timeout();
        test_finish_vs_timeout();
        test_duplicate_code();
        test_reset_mid_run();
        test_err_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
